nco_quad: RTL

Parametrised quadrature numerically controlled oscillator, the next-generation phase-accumulator NCO for the lab signal-generation path. It produces registered signed sine and cosine samples from a quarter-wave lookup table. Frequency is set through a load strobe that can be deferred to a phase-accumulator wrap, and phase modulation is per sample. It drives the DAC/mixer datapath and replaces the fixed single-output sine NCO.

---
 rtl/nco_quad.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nco_quad.sv
// nco_quad: quadrature phase-accumulator NCO with a quarter-wave sine table.
// Optional macro NCO_DITHER_EN adds LFSR dither on the truncated phase bits.
module nco_quad #(
  parameter int ACC_W        = 20,
  parameter int OUT_W        = 12,
  parameter int LUT_AW       = 10,
  parameter bit LOAD_ON_WRAP = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ACC_W-1:0]        phi_inc_i,
  input  logic                    inc_load,
  input  logic [ACC_W-1:0]        phase_mod_i,
  output logic signed [OUT_W-1:0] fsin_o,
  output logic signed [OUT_W-1:0] fcos_o,
  output logic                    out_valid,
  output logic                    wrap_o,
  output logic                    inc_pending_o
);
  localparam int  D       = ACC_W - LUT_AW - 2;
  localparam int  DEPTH   = 1 << LUT_AW;
  localparam int  MAG_W   = OUT_W - 1;
  localparam int  PH_W    = ACC_W - D;
  localparam real AMP     = real'((1 << (OUT_W - 1)) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  // Quarter-wave magnitude table, sampled at bin centres so no entry is zero.
  logic [MAG_W-1:0] lut [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lut
    localparam real VAL = AMP * $sin(HALF_PI * (real'(gi) + 0.5) / real'(DEPTH));
    assign lut[gi] = MAG_W'($rtoi(VAL + 0.5));
  end

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] inc_reg;
  logic [ACC_W-1:0] inc_stage_reg;
  logic [PH_W-1:0]  phase_reg;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] dither;
  logic             commit;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, inc_reg};
  // inc_reg == 0 commits immediately so the first load after reset is not stuck.
  assign commit  = inc_pending_o && (acc_sum[ACC_W] || (inc_reg == '0));

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr_reg;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_reg <= 16'hACE1;
    end else if (clken) begin
      lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    end
  end
  if (D > 0) begin : g_dither
    localparam int DW = (D > 16) ? 16 : D;
    assign dither = ACC_W'(lfsr_reg[DW-1:0]);
  end else begin : g_no_dither
    assign dither = '0;
  end
`else
  assign dither = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      inc_reg       <= '0;
      inc_stage_reg <= '0;
      inc_pending_o <= 1'b0;
      wrap_o        <= 1'b0;
      phase_reg     <= '0;
    end else if (clken) begin
      acc_reg   <= acc_sum[ACC_W-1:0];
      wrap_o    <= acc_sum[ACC_W];
      phase_reg <= PH_W'((acc_reg + phase_mod_i + dither) >> D);
      if (!LOAD_ON_WRAP) begin
        if (inc_load) inc_reg <= phi_inc_i;
      end else begin
        if (commit) inc_reg <= inc_stage_reg;
        if (inc_load) begin
          inc_stage_reg <= phi_inc_i;
          inc_pending_o <= 1'b1;
        end else if (commit) begin
          inc_pending_o <= 1'b0;
        end
      end
    end
  end

  logic [1:0]        quad;
  logic [LUT_AW-1:0] addr;
  logic [LUT_AW-1:0] sin_addr;
  logic [LUT_AW-1:0] cos_addr;

  assign quad     = phase_reg[PH_W-1 -: 2];
  assign addr     = phase_reg[LUT_AW-1:0];
  // Odd quadrants read the table mirrored; cosine is the sine one quadrant ahead.
  assign sin_addr = quad[0] ? ~addr : addr;
  assign cos_addr = quad[0] ? addr : ~addr;

  logic [MAG_W-1:0]        sin_mag_reg;
  logic [MAG_W-1:0]        cos_mag_reg;
  logic                    sin_neg_reg;
  logic                    cos_neg_reg;
  logic signed [OUT_W-1:0] sin_pos;
  logic signed [OUT_W-1:0] cos_pos;
  logic [1:0]              fill_reg;

  assign sin_pos = {1'b0, sin_mag_reg};
  assign cos_pos = {1'b0, cos_mag_reg};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sin_mag_reg <= '0;
      cos_mag_reg <= '0;
      sin_neg_reg <= 1'b0;
      cos_neg_reg <= 1'b0;
      fsin_o      <= '0;
      fcos_o      <= '0;
      fill_reg    <= '0;
      out_valid   <= 1'b0;
    end else if (clken) begin
      sin_mag_reg <= lut[sin_addr];
      cos_mag_reg <= lut[cos_addr];
      sin_neg_reg <= quad[1];
      cos_neg_reg <= quad[1] ^ quad[0];
      fsin_o      <= sin_neg_reg ? -sin_pos : sin_pos;
      fcos_o      <= cos_neg_reg ? -cos_pos : cos_pos;
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
      if (fill_reg == 2'd2) out_valid <= 1'b1;
    end
  end
endmodule
